// File: rtl/onehot_pkg.sv
// Shared encodings for the one-hot sequencer: mode select values and BOUNCE scan direction.
package onehot_pkg;

  typedef enum logic [1:0] {
    MODE_DECODE   = 2'd0,
    MODE_ROT_UP   = 2'd1,
    MODE_ROT_DOWN = 2'd2,
    MODE_BOUNCE   = 2'd3
  } mode_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

endpackage

// File: rtl/onehot_prescaler.sv
// Step-rate prescaler: tick is combinational from the count and en; the count advances only when en is high.
// en low holds the count exactly, so no partial period is lost; clr (load) restarts the period.
module onehot_prescaler #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  // >= rather than == so that lowering div mid-count fires on the next enabled cycle
  assign tick = en & ~rst & (cnt >= div);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      if (tick) cnt <= '0;
      else      cnt <= cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/onehot_sequencer.sv
// One-hot LED driver: binary decode, ring counter up/down or bouncing scanner; onehot_out follows pos with no extra stage.
// DECODE latency is 1 clk; stepping modes advance once per div+1 enabled cycles, en low freezes everything but load.
module onehot_sequencer
  import onehot_pkg::*;
#(
  parameter int N     = 8,
  parameter int W     = $clog2(N),
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [W-1:0]     sel,
  input  logic             load,
  input  logic [DIV_W-1:0] div,
  output logic [N-1:0]     onehot_out,
  output logic [W-1:0]     pos,
  output logic             tick,
  output logic             wrap
);

  localparam logic [W-1:0] LAST  = W'(N - 1);
  localparam logic [W:0]   N_EXT = (W + 1)'(N);

  dir_t         dir, dir_n;
  logic [W-1:0] pos_n;
  logic         wrap_n;
  logic [W-1:0] sel_c;

  // Positions are modulo N, not 2^W, so out-of-range selects pin to the top bit
  assign sel_c = ({1'b0, sel} >= N_EXT) ? LAST : sel;

  onehot_prescaler #(.DIV_W(DIV_W)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .clr  (load),
    .div  (div),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pos  <= '0;
      dir  <= DIR_UP;
      wrap <= 1'b0;
    end else begin
      pos  <= pos_n;
      dir  <= dir_n;
      wrap <= wrap_n;
    end
  end

  always_comb begin
    pos_n  = pos;
    dir_n  = dir;
    wrap_n = 1'b0;
    if (load) begin
      pos_n = sel_c;
      dir_n = DIR_UP;
    end else if (en) begin
      case (mode_t'(mode))
        MODE_DECODE: pos_n = sel_c;
        MODE_ROT_UP: begin
          if (tick) begin
            if (pos == LAST) begin
              pos_n  = '0;
              wrap_n = 1'b1;
            end else begin
              pos_n = pos + W'(1);
            end
          end
        end
        MODE_ROT_DOWN: begin
          if (tick) begin
            if (pos == '0) begin
              pos_n  = LAST;
              wrap_n = 1'b1;
            end else begin
              pos_n = pos - W'(1);
            end
          end
        end
        MODE_BOUNCE: begin
          if (tick) begin
            // Landing on an endpoint reverses immediately so it is held for one step only
            if (dir == DIR_UP) begin
              if (pos == LAST) begin
                pos_n = pos - W'(1);
                dir_n = DIR_DOWN;
              end else begin
                pos_n = pos + W'(1);
                if (pos_n == LAST) begin
                  dir_n  = DIR_DOWN;
                  wrap_n = 1'b1;
                end
              end
            end else begin
              if (pos == '0) begin
                pos_n = pos + W'(1);
                dir_n = DIR_UP;
              end else begin
                pos_n = pos - W'(1);
                if (pos_n == '0) begin
                  dir_n  = DIR_UP;
                  wrap_n = 1'b1;
                end
              end
            end
          end
        end
        default: pos_n = pos;
      endcase
    end
  end

  always_comb begin
    onehot_out = N'(1) << pos;
  end

endmodule

// File: doc/onehot_sequencer.md
# onehot_sequencer

Parametrised one-hot LED driver, successor to the fixed 3-to-8 combinational decoder. It decodes a binary select to a one-hot vector of configurable width. It can also run that one-hot bit autonomously as a ring counter (up or down) or as a bouncing scanner, paced by an on-block programmable prescaler. It sits between the input switches and the LED outputs of the tile.

## Interface
- `N`, 8: number of one-hot outputs; legal range N ≥ 2.
- `W`, `$clog2(N)`: select/position width (derived, not overridden).
- `DIV_W`, 16: prescaler width.

- `clk` input 1: single clock, all state on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `en` input 1: advance enable; low freezes the prescaler and the position.
- `mode` input 2: 0 DECODE, 1 ROT_UP, 2 ROT_DOWN, 3 BOUNCE.
- `sel` input W: decode value (DECODE) / load value (`load`).
- `load` input 1: synchronous preload of position from `sel`.
- `div` input DIV_W: step period minus one, in clk cycles.
- `onehot_out` output N: `1 << pos`; exactly one bit set at all times.
- `pos` output W: current position register.
- `tick` output 1: prescaler step strobe (combinational from state and `en`).
- `wrap` output 1: registered one-cycle pulse on wrap/reversal.

## Operation
- **Reset (rst=1 at edge):**
  - `pos`=0, so `onehot_out`=1 (bit 0).
  - Direction = up, prescaler count = 0, `wrap`=0.
  - `tick`=0 while `rst` is high.
- **Select clamp:** `sel` ≥ N is treated as N-1 wherever `sel` is used.
- **Prescaler:**
  - `tick` = `en` & (cnt ≥ `div`).
  - On an edge with `en`: if `tick`, cnt ← 0; else cnt ← cnt+1.
  - Comparing with ≥ means that lowering `div` mid-count fires on the next enabled cycle.
  - `div`=0 gives `tick` on every enabled cycle.
- **Priority per edge:** `rst` > `load` > mode action.
- **`load`:** `pos` ← clamp(`sel`), direction ← up, cnt ← 0, `wrap` ← 0. Independent of `en`.
- **DECODE:**
  - When `en`: `pos` ← clamp(`sel`) every cycle. Prescaler runs but is ignored.
  - `wrap` is never asserted.
- **ROT_UP** (on `tick`):
  - `pos` ← `pos`+1.
  - N-1 wraps to 0; `wrap` ← 1.
- **ROT_DOWN** (on `tick`):
  - `pos` ← `pos`-1.
  - 0 wraps to N-1; `wrap` ← 1.
- **BOUNCE state machine** (states UP, DOWN), on `tick`:
  - UP: `pos`+1. If the new `pos` is N-1, go to DOWN and set `wrap` ← 1.
  - DOWN: `pos`-1. If the new `pos` is 0, go to UP and set `wrap` ← 1.
  - If `pos` is N-1 while in UP (after a load or mode change), step down instead and go to DOWN.
  - If `pos` is 0 while in DOWN, step up and go to UP.
  - Endpoints are held for exactly one step period; no double-visit.
- **`wrap`:** is 0 on every edge that does not set it, so it is a single-cycle pulse.
- **Mode change:**
  - Takes effect at the next edge.
  - `pos` and cnt are preserved.
  - Direction is preserved unless overridden by the endpoint rule.
- **Width rule:** `pos` arithmetic is modulo N, not 2^W; the N-1 ↔ 0 boundaries are explicit compares.

## Timing
- DECODE latency: `sel` → `onehot_out` is 1 clk.
- Step rate in ROT and BOUNCE: one step per (`div`+1) enabled cycles.
  - The first step after reset or `load` lands on edge `div`+1.
- `onehot_out` is decoded from the `pos` register (no extra register stage).
  - It changes in the same cycle as `pos` and is glitch-free at the register boundary.
- `wrap` asserts in the same cycle `pos` shows the boundary value.
- `en` low mid-count: cnt is held and resumes without loss.
- `rst` or `load` mid-count: the count is discarded.

## Structure
- Package `onehot_pkg` holds:
  - the mode encodings (`MODE_DECODE`, `MODE_ROT_UP`, `MODE_ROT_DOWN`, `MODE_BOUNCE`);
  - the direction constants (`DIR_UP`, `DIR_DOWN`).
- Sub-module `onehot_prescaler` (params `DIV_W`):
  - inputs `clk`, `rst`, `en`, `clr`, `div`;
  - output `tick`.
  - `load` drives `clr`.
- Top-level holds the position/direction register, the BOUNCE FSM, the clamp, and the binary→one-hot decode.

## Test plan
All scenarios use N=8.

- **Reset:** assert `rst` with any inputs → `onehot_out`=0x01, `pos`=0, `wrap`=0; `tick`=0 while `rst` high.
- **DECODE:**
  - `mode`=0, `en`=1, sweep `sel` 0..7 → `onehot_out`=0x01,0x02,…,0x80, each one clk after `sel`.
  - N=6 variant, `sel`=7 → `onehot_out`=0x20.
- **ROT_UP:** `div`=2, `en`=1 from reset → `pos` steps every 3 clks: 1,2,…,7,0. `wrap` is high only in the cycle `pos` becomes 0 (edge 24).
- **ROT_DOWN:** `load` `sel`=0, `div`=0 → `pos` = 7,6,5,… on consecutive edges. `wrap` on the first step.
- **BOUNCE:**
  - `div`=0 from reset → `pos` = 1..7,6..0,1…
  - `wrap` pulses when `pos` reaches 7 and when it reaches 0. 14-cycle period.
- **Freeze and load:**
  - `en`=0 for 5 clks mid-count in ROT_UP → `pos` and cnt are unchanged, then resume with the remaining count.
  - `load` `sel`=5 simultaneous with `tick` → `pos`=5 (load wins) and cnt=0.
